// File: rtl/axis_rx_pkg.sv
// rtl/axis_rx_pkg.sv - shared types and helpers for the AXI-Stream receive buffer
package axis_rx_pkg;

    // Input-side packet state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Free-running write/read counts, beat counter and packet counter.
    typedef logic [7:0] count_t;

    // Entries held = written minus read, modulo 256.
    function automatic count_t occupancy(input count_t wr_count, input count_t rd_count);
        return wr_count - rd_count;
    endfunction

endpackage

// File: rtl/axis_rx_store.sv
// rtl/axis_rx_store.sv - entry storage with wrapping pointers and full/empty flags
//
// Ports:
//   clk, rst, clear    clock, synchronous active-high reset, synchronous flush
//   wr_en/wr_last/wr_data   write one {last, data} entry at the write pointer
//   rd_en              pop the head entry
//   rd_last/rd_data    head entry fields (data forced to 0 when empty)
//   full/empty         derived from registered counts only
module axis_rx_store
    import axis_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic             wr_last,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_last,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    count_t           wr_count_q, wr_count_d;
    count_t           rd_count_q, rd_count_d;
    count_t           occ;
    entry_t           head;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (wr_en) begin
            // DEPTH need not be a power of two, so wrap explicitly.
            wr_ptr_d   = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            wr_count_d = wr_count_q + 8'd1;
        end
        if (rd_en) begin
            rd_ptr_d   = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            rd_count_d = rd_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Payload array needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{last: wr_last, data: wr_data};
        end
    end

    always_comb begin
        occ     = occupancy(wr_count_q, rd_count_q);
        full    = (occ == count_t'(DEPTH - 1));
        empty   = (occ == 8'd0);
        head    = mem_q[rd_ptr_q];
        rd_data = empty ? '0 : head.data;
        rd_last = ~empty & head.last;
    end

endmodule

// File: rtl/axis_rx_buffer.sv
// rtl/axis_rx_buffer.sv - AXI-Stream receive buffer with length limit and packet mode
//
// Ports:
//   clk, rst, clear     clock, synchronous active-high reset, synchronous flush
//   s_tvalid/s_tready/s_tdata/s_tlast   upstream AXI-Stream slave
//   rd_vld/rd_rdy/data_out/last         first-word-fall-through read port
//   pkt_count           complete packets held
//   len_err             one-cycle pulse after a packet is truncated
module axis_rx_buffer
    import axis_rx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int MAX_LEN  = 6,
    parameter int PKT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tlast,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] data_out,
    output logic             last,
    output logic [7:0]       pkt_count,
    output logic             len_err
);

    state_t state_q, state_d;
    count_t beat_cnt_q, beat_cnt_d;
    count_t pkt_count_q, pkt_count_d;
    logic   len_err_q, len_err_d;

    logic             full, empty;
    logic             head_last;
    logic [WIDTH-1:0] head_data;
    logic             accept;
    logic             wr_en, wr_last;
    logic             reach_max;
    logic             rd_fire;

    axis_rx_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_last (wr_last),
        .wr_data (s_tdata),
        .rd_en   (rd_fire),
        .rd_last (head_last),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty)
    );

    // Handshakes in a clear cycle are ignored on both sides.
    assign accept    = s_tvalid & s_tready & ~clear;
    assign reach_max = ((beat_cnt_q + 8'd1) == count_t'(MAX_LEN));

    // State register
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = 1'b0;
        case (state_q)
            IDLE, BODY: begin
                if (accept) begin
                    if (reach_max && !s_tlast) begin
                        // Over-long packet: close it here, drop the remainder.
                        state_d    = DISCARD;
                        beat_cnt_d = '0;
                        len_err_d  = 1'b1;
                    end else if (wr_last) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = BODY;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            DISCARD: begin
                if (accept && s_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Output logic: s_tready depends only on registered state.
    always_comb begin
        s_tready = (state_q == DISCARD) ? 1'b1 : ~full;
        wr_en    = accept & (state_q != DISCARD);
        wr_last  = s_tlast | reach_max;
    end

    // Read side qualification and packet counting
    always_comb begin
        rd_vld  = ~empty & ((PKT_MODE == 0) || (pkt_count_q != 8'd0));
        rd_fire = rd_vld & rd_rdy & ~clear;
        pkt_count_d = pkt_count_q;
        case ({wr_en & wr_last, rd_fire & head_last})
            2'b10:   pkt_count_d = pkt_count_q + 8'd1;
            2'b01:   pkt_count_d = pkt_count_q - 8'd1;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign data_out  = head_data;
    assign last      = rd_vld & head_last;
    assign pkt_count = pkt_count_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_axis_rx_buffer.sv
// tb/tb_axis_rx_buffer.sv - self-checking bench for axis_rx_buffer
module tb_axis_rx_buffer;

    logic       clk;
    logic       rst, clear;
    logic       s_tvalid, s_tlast, rd_rdy;
    logic [7:0] s_tdata;

    logic       s_tready, rd_vld, last, len_err;
    logic [7:0] data_out, pkt_count;
    logic       p_tready, p_rd_vld, p_last, p_len_err;
    logic [7:0] p_data_out, p_pkt_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axis_rx_buffer #(.WIDTH(8), .DEPTH(8), .MAX_LEN(6), .PKT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .data_out(data_out), .last(last),
        .pkt_count(pkt_count), .len_err(len_err)
    );

    axis_rx_buffer #(.WIDTH(8), .DEPTH(8), .MAX_LEN(6), .PKT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .s_tvalid(s_tvalid), .s_tready(p_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .rd_vld(p_rd_vld), .rd_rdy(rd_rdy), .data_out(p_data_out), .last(p_last),
        .pkt_count(p_pkt_count), .len_err(p_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk;
        logic       rst;
        logic       clr;
        logic       vld;
        logic [7:0] data;
        logic       tlast;
        logic       rdy;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_data;
        logic       e_last;
        logic [7:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; rd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        @(negedge clk);
        rd_rdy = 1'b0; s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    endtask

    task automatic expect_rd(input logic [7:0] d, input logic l);
        @(negedge clk);
        s_tvalid = 1'b0; rd_rdy = 1'b1;
        #1;
        chk("rd_vld", int'(rd_vld), 1);
        chk("rd_data", int'(data_out), int'(d));
        chk("rd_last", int'(last), int'(l));
    endtask

    initial begin
        int pulses;
        int sent, got;
        logic [8:0] expq [$];
        logic [8:0] e;

        rst = 1'b1; clear = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; rd_rdy = 1'b0;

        //            chk  rst  clr  vld  data   tl   rdy  e_rdy e_vld e_data e_last e_cnt e_err
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,8'd0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,8'd0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,8'h11,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,8'h22,1'b0,1'b1, 1'b1,1'b1,8'h11,1'b0,8'd0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,8'h33,1'b1,1'b1, 1'b1,1'b1,8'h22,1'b0,8'd0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b1,8'h33,1'b1,8'd1,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd0,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,8'hA1,1'b1,1'b0, 1'b1,1'b0,8'h00,1'b0,8'd0,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,8'hA2,1'b0,1'b0, 1'b1,1'b1,8'hA1,1'b1,8'd1,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b1,8'hA3,1'b0,1'b1, 1'b1,1'b1,8'hA1,1'b1,8'd1,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,8'd0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b1,8'hB1,1'b1,1'b0, 1'b1,1'b0,8'h00,1'b0,8'd0,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,8'hB1,1'b1,8'd1,1'b0};

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; clear = vecs[i].clr; s_tvalid = vecs[i].vld;
            s_tdata = vecs[i].data; s_tlast = vecs[i].tlast; rd_rdy = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                chk($sformatf("v%0d_tready", i), int'(s_tready), int'(vecs[i].e_rdy));
                chk($sformatf("v%0d_rd_vld", i), int'(rd_vld), int'(vecs[i].e_vld));
                chk($sformatf("v%0d_data", i), int'(data_out), int'(vecs[i].e_data));
                chk($sformatf("v%0d_last", i), int'(last), int'(vecs[i].e_last));
                chk($sformatf("v%0d_pkt_count", i), int'(pkt_count), int'(vecs[i].e_cnt));
                chk($sformatf("v%0d_len_err", i), int'(len_err), int'(vecs[i].e_err));
            end
        end

        // Fill to capacity with single-beat packets, then one read.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1; s_tdata = 8'(i); s_tlast = 1'b1;
            #1 chk($sformatf("fill_tready%0d", i), int'(s_tready), (i < 7) ? 1 : 0);
        end
        @(negedge clk);
        s_tvalid = 1'b0; rd_rdy = 1'b1;
        #1;
        chk("full_pkt_count", int'(pkt_count), 7);
        chk("full_head", int'(data_out), 0);
        chk("full_tready_during_read", int'(s_tready), 0);
        @(negedge clk);
        rd_rdy = 1'b0;
        #1;
        chk("after_read_tready", int'(s_tready), 1);
        chk("after_read_pkt_count", int'(pkt_count), 6);
        chk("after_read_head", int'(data_out), 1);

        // Truncation of a 10-beat packet at MAX_LEN = 6.
        do_reset();
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1; s_tdata = 8'(8'h40 + i); s_tlast = (i == 10);
            #1;
            chk($sformatf("trunc_tready%0d", i), int'(s_tready), 1);
            if (i == 7) chk("trunc_len_err_timing", int'(len_err), 1);
            pulses += int'(len_err);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        pulses += int'(len_err);
        chk("trunc_len_err_pulses", pulses, 1);
        chk("trunc_pkt_count", int'(pkt_count), 1);
        for (int i = 1; i <= 6; i++) expect_rd(8'(8'h40 + i), (i == 6));
        push(8'h50, 1'b0);
        push(8'h51, 1'b1);
        expect_rd(8'h50, 1'b0);
        expect_rd(8'h51, 1'b1);
        @(negedge clk);
        rd_rdy = 1'b0;
        #1;
        chk("trunc_drained_vld", int'(rd_vld), 0);
        chk("trunc_drained_cnt", int'(pkt_count), 0);

        // Packet mode: data held until the last beat is stored.
        do_reset();
        push(8'h61, 1'b0);
        push(8'h62, 1'b0);
        #1;
        chk("pkt_vld_partial1", int'(p_rd_vld), 0);
        chk("nopkt_vld_early", int'(rd_vld), 1);
        chk("nopkt_data_early", int'(data_out), 8'h61);
        push(8'h63, 1'b1);
        #1 chk("pkt_vld_partial2", int'(p_rd_vld), 0);
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        chk("pkt_vld_complete", int'(p_rd_vld), 1);
        chk("pkt_count_complete", int'(p_pkt_count), 1);
        chk("pkt_head_data", int'(p_data_out), 8'h61);
        chk("pkt_head_last", int'(p_last), 0);

        // Continuous stream across the pointer wrap.
        do_reset();
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 100 && (sent < 20 || got < 20); cyc++) begin
            @(negedge clk);
            rd_rdy = 1'b1; s_tvalid = (sent < 20);
            s_tdata = 8'(8'h80 + sent); s_tlast = ((sent % 4) == 3);
            #1;
            if (rd_vld) begin
                if (expq.size() == 0) begin
                    chk("wrap_unexpected_read", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("wrap_data", int'(data_out), int'(e[7:0]));
                    chk("wrap_last", int'(last), int'(e[8]));
                    got++;
                end
            end
            if (s_tvalid && s_tready) begin
                expq.push_back({s_tlast, s_tdata});
                sent++;
            end
        end
        chk("wrap_received", got, 20);

        // clear in the middle of a packet, with both handshakes live.
        for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 1'b0);
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = 8'hC3; s_tlast = 1'b0; clear = 1'b1; rd_rdy = 1'b1;
        #1 chk("clear_pre_head", int'(data_out), 8'hC0);
        @(negedge clk);
        clear = 1'b0; s_tvalid = 1'b0; rd_rdy = 1'b0;
        #1;
        chk("clear_rd_vld", int'(rd_vld), 0);
        chk("clear_data", int'(data_out), 0);
        chk("clear_pkt_count", int'(pkt_count), 0);
        chk("clear_tready", int'(s_tready), 1);
        push(8'hD0, 1'b1);
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        chk("post_clear_data", int'(data_out), 8'hD0);
        chk("post_clear_last", int'(last), 1);
        chk("post_clear_cnt", int'(pkt_count), 1);

        // Reset mid-packet restarts the beat counter.
        do_reset();
        push(8'hE0, 1'b0);
        push(8'hE1, 1'b0);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'(8'hF0 + i), (i == 5));
            #1 pulses += int'(len_err);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        pulses += int'(len_err);
        chk("rst_mid_no_len_err", pulses, 0);
        chk("rst_mid_pkt_count", int'(pkt_count), 1);
        chk("rst_mid_head", int'(data_out), 8'hF0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
